// File: rtl/tex_texel_gather.sv
// Texel gather: queues quad headers, collects four corner beats per quad in any order,
// then presents one sampler request with the full 2x2 texel set.
`ifndef TEX_FORMAT_BITS
`define TEX_FORMAT_BITS 4
`endif
`ifndef TEX_BLEND_FRAC
`define TEX_BLEND_FRAC 8
`endif

module tex_texel_gather #(
  parameter int unsigned NUM_LANES = 4,
  parameter int unsigned REQ_TAGW  = 8,
  parameter int unsigned HDR_DEPTH = 4
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     hdr_valid,
  input  logic [`TEX_FORMAT_BITS-1:0]              hdr_format,
  input  logic [NUM_LANES*2*`TEX_BLEND_FRAC-1:0]   hdr_blends,
  input  logic [REQ_TAGW-1:0]                      hdr_tag,
  output logic                                     hdr_ready,
  input  logic                                     mem_valid,
  input  logic [1:0]                               mem_idx,
  input  logic [NUM_LANES*32-1:0]                  mem_data,
  output logic                                     mem_ready,
  output logic                                     smp_valid,
  output logic [`TEX_FORMAT_BITS-1:0]              smp_format,
  output logic [NUM_LANES*2*`TEX_BLEND_FRAC-1:0]   smp_blends,
  output logic [NUM_LANES*4*32-1:0]                smp_data,
  output logic [REQ_TAGW-1:0]                      smp_tag,
  input  logic                                     smp_ready,
  output logic                                     dup_err
);

  localparam int unsigned FmtW   = `TEX_FORMAT_BITS;
  localparam int unsigned BlendW = NUM_LANES * 2 * `TEX_BLEND_FRAC;
  localparam int unsigned PtrW   = (HDR_DEPTH > 1) ? $clog2(HDR_DEPTH) : 1;
  localparam int unsigned CntW   = PtrW + 1;

  typedef enum logic [0:0] {StGather, StIssue} state_e;

  state_e            state_q;
  logic [3:0]        mask_q;
  logic              dup_err_q;
  logic [31:0]       texel_q [NUM_LANES][4];

  logic [FmtW-1:0]     fmt_mem   [HDR_DEPTH];
  logic [BlendW-1:0]   blend_mem [HDR_DEPTH];
  logic [REQ_TAGW-1:0] tag_mem   [HDR_DEPTH];
  logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]     count_q;

  logic       full, empty, push, pop, beat;
  logic [3:0] idx_bit, mask_upd;

  assign full      = (count_q == CntW'(HDR_DEPTH));
  assign empty     = (count_q == '0);
  assign hdr_ready = !full;
  assign mem_ready = (state_q == StGather) && !empty;
  assign smp_valid = (state_q == StIssue);
  assign dup_err   = dup_err_q;

  assign push     = hdr_valid && !full;
  assign pop      = smp_valid && smp_ready;
  assign beat     = mem_valid && mem_ready;
  assign idx_bit  = 4'b0001 << mem_idx;
  assign mask_upd = mask_q | idx_bit;

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fmt_mem[wr_ptr_q]   <= hdr_format;
      blend_mem[wr_ptr_q] <= hdr_blends;
      tag_mem[wr_ptr_q]   <= hdr_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (beat) begin
      for (int l = 0; l < NUM_LANES; l++) begin
        texel_q[l][mem_idx] <= mem_data[l*32 +: 32];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= StGather;
      mask_q    <= '0;
      dup_err_q <= 1'b0;
    end else begin
      unique case (state_q)
        StGather: begin
          if (beat) begin
            // A repeated corner overwrites its data but never advances completion.
            if (mask_q[mem_idx]) dup_err_q <= 1'b1;
            mask_q <= mask_upd;
            if (mask_upd == 4'b1111) state_q <= StIssue;
          end
        end
        StIssue: begin
          if (smp_ready) begin
            mask_q  <= '0;
            state_q <= StGather;
          end
        end
        default: state_q <= StGather;
      endcase
    end
  end

  // Request fields are forced to zero outside ISSUE so reset and idle present clean outputs.
  always_comb begin
    smp_format = '0;
    smp_blends = '0;
    smp_tag    = '0;
    smp_data   = '0;
    if (state_q == StIssue) begin
      smp_format = fmt_mem[rd_ptr_q];
      smp_blends = blend_mem[rd_ptr_q];
      smp_tag    = tag_mem[rd_ptr_q];
      for (int l = 0; l < NUM_LANES; l++) begin
        for (int c = 0; c < 4; c++) begin
          smp_data[(l*4+c)*32 +: 32] = texel_q[l][c];
        end
      end
    end
  end

endmodule

// File: tb/tb_tex_texel_gather.sv
// Directed bench for tex_texel_gather: ordering, backpressure, FIFO full/wrap, duplicates, reset.
`ifndef TEX_FORMAT_BITS
`define TEX_FORMAT_BITS 4
`endif
`ifndef TEX_BLEND_FRAC
`define TEX_BLEND_FRAC 8
`endif

module tb_tex_texel_gather;
  localparam int unsigned NL = 4;
  localparam int unsigned TW = 8;
  localparam int unsigned FW = `TEX_FORMAT_BITS;
  localparam int unsigned BW = NL * 2 * `TEX_BLEND_FRAC;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic              hdr_valid;
  logic [FW-1:0]     hdr_format;
  logic [BW-1:0]     hdr_blends;
  logic [TW-1:0]     hdr_tag;
  logic              hdr_ready;
  logic              mem_valid;
  logic [1:0]        mem_idx;
  logic [NL*32-1:0]  mem_data;
  logic              mem_ready;
  logic              smp_valid;
  logic [FW-1:0]     smp_format;
  logic [BW-1:0]     smp_blends;
  logic [NL*128-1:0] smp_data;
  logic [TW-1:0]     smp_tag;
  logic              smp_ready;
  logic              dup_err;

  int n_chk = 0;
  int n_pass = 0;

  tex_texel_gather #(
    .NUM_LANES(NL),
    .REQ_TAGW (TW),
    .HDR_DEPTH(4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .hdr_valid (hdr_valid),
    .hdr_format(hdr_format),
    .hdr_blends(hdr_blends),
    .hdr_tag   (hdr_tag),
    .hdr_ready (hdr_ready),
    .mem_valid (mem_valid),
    .mem_idx   (mem_idx),
    .mem_data  (mem_data),
    .mem_ready (mem_ready),
    .smp_valid (smp_valid),
    .smp_format(smp_format),
    .smp_blends(smp_blends),
    .smp_data  (smp_data),
    .smp_tag   (smp_tag),
    .smp_ready (smp_ready),
    .dup_err   (dup_err)
  );

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Lane l of a corner beat carries base + l*0x100.
  function automatic logic [NL*32-1:0] mk_beat(input logic [31:0] base);
    logic [NL*32-1:0] d;
    for (int l = 0; l < NL; l++) d[l*32 +: 32] = base + 32'(l * 256);
    return d;
  endfunction

  function automatic logic [NL*128-1:0] mk_exp(input logic [31:0] b0, input logic [31:0] b1,
                                               input logic [31:0] b2, input logic [31:0] b3);
    logic [NL*128-1:0] d;
    logic [31:0] b [4];
    b[0] = b0; b[1] = b1; b[2] = b2; b[3] = b3;
    for (int l = 0; l < NL; l++)
      for (int c = 0; c < 4; c++) d[(l*4+c)*32 +: 32] = b[c] + 32'(l * 256);
    return d;
  endfunction

  task automatic beat(input logic [1:0] idx, input logic [31:0] base);
    mem_valid = 1'b1;
    mem_idx   = idx;
    mem_data  = mk_beat(base);
    chk("beat_ready", mem_ready, 1'b1);
    step;
    mem_valid = 1'b0;
  endtask

  task automatic push_hdr(input logic [TW-1:0] tag);
    hdr_valid  = 1'b1;
    hdr_tag    = tag;
    hdr_format = 4'h5;
    hdr_blends = {8{tag}};
    chk("push_ready", hdr_ready, 1'b1);
    step;
    hdr_valid = 1'b0;
  endtask

  task automatic quad_beats(input logic [31:0] base);
    for (int c = 0; c < 4; c++) beat(2'(c), base + 32'(c));
  endtask

  task automatic issue_chk(input logic [TW-1:0] tag, input logic [NL*128-1:0] exp);
    chk("issue_valid", smp_valid, 1'b1);
    chk("issue_tag", smp_tag, tag);
    chk("issue_data", smp_data, exp);
    chk("issue_mem_ready", mem_ready, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; hdr_valid = 1'b0; hdr_format = '0; hdr_blends = '0; hdr_tag = '0;
    mem_valid = 1'b0; mem_idx = '0; mem_data = '0; smp_ready = 1'b1;
    step; step;
    chk("rst_hdr_ready", hdr_ready, 1'b1);
    chk("rst_mem_ready", mem_ready, 1'b0);
    chk("rst_smp_valid", smp_valid, 1'b0);
    chk("rst_dup_err", dup_err, 1'b0);
    chk("rst_smp_data", smp_data, '0);
    chk("rst_smp_tag", smp_tag, '0);
    reset = 1'b1;

    // Single quad, in order; a beat offered alongside the first header must be ignored.
    hdr_valid = 1'b1; hdr_format = 4'h3; hdr_blends = 64'h0123_4567_89ab_cdef; hdr_tag = 8'h11;
    mem_valid = 1'b1; mem_idx = 2'd0; mem_data = mk_beat(32'hEE);
    chk("t1_beat_before_hdr", mem_ready, 1'b0);
    step;
    hdr_valid = 1'b0; mem_valid = 1'b0;
    chk("t1_ready_after_push", mem_ready, 1'b1);
    beat(2'd0, 32'hA0);
    beat(2'd1, 32'hA1);
    beat(2'd2, 32'hA2);
    chk("t1_no_early_issue", smp_valid, 1'b0);
    beat(2'd3, 32'hA3);
    issue_chk(8'h11, mk_exp(32'hA0, 32'hA1, 32'hA2, 32'hA3));
    chk("t1_lane0", smp_data[127:0], {32'hA3, 32'hA2, 32'hA1, 32'hA0});
    chk("t1_format", smp_format, 4'h3);
    chk("t1_blends", smp_blends, 64'h0123_4567_89ab_cdef);
    step;
    chk("t1_after_pop_valid", smp_valid, 1'b0);
    chk("t1_after_pop_mem_ready", mem_ready, 1'b0);
    chk("t1_dup_err", dup_err, 1'b0);

    // Out-of-order corners.
    push_hdr(8'h22);
    beat(2'd3, 32'hC3);
    beat(2'd1, 32'hC1);
    beat(2'd0, 32'hC0);
    chk("t2_no_early_issue", smp_valid, 1'b0);
    beat(2'd2, 32'hC2);
    issue_chk(8'h22, mk_exp(32'hC0, 32'hC1, 32'hC2, 32'hC3));
    step;
    chk("t2_single_issue", smp_valid, 1'b0);
    chk("t2_dup_err", dup_err, 1'b0);

    // Backpressure: six stalled cycles, a second header queued during the stall.
    smp_ready = 1'b0;
    push_hdr(8'h33);
    quad_beats(32'h330);
    for (int i = 0; i < 6; i++) begin
      issue_chk(8'h33, mk_exp(32'h330, 32'h331, 32'h332, 32'h333));
      chk("t3_hold_format", smp_format, 4'h5);
      if (i == 0) begin
        hdr_valid = 1'b1; hdr_tag = 8'h34;
      end
      step;
      hdr_valid = 1'b0;
    end
    smp_ready = 1'b1;
    issue_chk(8'h33, mk_exp(32'h330, 32'h331, 32'h332, 32'h333));
    step;
    chk("t3_back_to_gather", smp_valid, 1'b0);
    chk("t3_mem_ready_next", mem_ready, 1'b1);
    quad_beats(32'h340);
    issue_chk(8'h34, mk_exp(32'h340, 32'h341, 32'h342, 32'h343));
    step;

    // FIFO full, pop with a waiting push, then ordering across the pointer wrap.
    hdr_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      hdr_tag = 8'(8'h40 + k);
      chk("t4_fill_ready", hdr_ready, 1'b1);
      step;
    end
    hdr_tag = 8'h44;
    chk("t4_full", hdr_ready, 1'b0);
    step;
    chk("t4_full_held", hdr_ready, 1'b0);
    quad_beats(32'h400);
    issue_chk(8'h40, mk_exp(32'h400, 32'h401, 32'h402, 32'h403));
    chk("t4_full_pop_cycle", hdr_ready, 1'b0);
    step;
    chk("t4_ready_after_pop", hdr_ready, 1'b1);
    step;
    hdr_valid = 1'b0;
    chk("t4_full_again", hdr_ready, 1'b0);
    for (int k = 1; k < 8; k++) begin
      quad_beats(32'(k * 16 + 32'h400));
      issue_chk(8'(8'h40 + k), mk_exp(32'(k * 16 + 32'h400), 32'(k * 16 + 32'h401),
                                      32'(k * 16 + 32'h402), 32'(k * 16 + 32'h403)));
      if (k == 4) begin
        hdr_valid = 1'b1; hdr_tag = 8'h45; hdr_blends = {8{8'h45}};
      end
      step;
      hdr_valid = 1'b0;
      if (k == 4) begin
        chk("t4_push_pop_same", mem_ready, 1'b1);
        push_hdr(8'h46);
        push_hdr(8'h47);
      end
    end
    chk("t4_drained", mem_ready, 1'b0);

    // Duplicate corner: last write wins, completion still needs four distinct corners.
    push_hdr(8'h55);
    beat(2'd0, 32'hD0);
    chk("t5_no_dup_yet", dup_err, 1'b0);
    beat(2'd0, 32'hB0);
    chk("t5_dup_set", dup_err, 1'b1);
    beat(2'd1, 32'hE1);
    beat(2'd2, 32'hE2);
    chk("t5_no_early_issue", smp_valid, 1'b0);
    beat(2'd3, 32'hE3);
    issue_chk(8'h55, mk_exp(32'hB0, 32'hE1, 32'hE2, 32'hE3));
    step;
    chk("t5_dup_sticky", dup_err, 1'b1);
    chk("t5_single_issue", smp_valid, 1'b0);

    // Reset mid-quad discards partial beats and queued headers.
    push_hdr(8'h66);
    push_hdr(8'h67);
    beat(2'd0, 32'h60);
    beat(2'd1, 32'h61);
    reset = 1'b0;
    step;
    reset = 1'b1;
    chk("t6_hdr_ready", hdr_ready, 1'b1);
    chk("t6_mem_ready", mem_ready, 1'b0);
    chk("t6_smp_valid", smp_valid, 1'b0);
    chk("t6_dup_cleared", dup_err, 1'b0);
    mem_valid = 1'b1; mem_idx = 2'd2; mem_data = mk_beat(32'h99);
    step;
    chk("t6_no_hdr_no_beat", mem_ready, 1'b0);
    mem_valid = 1'b0;
    push_hdr(8'h68);
    beat(2'd2, 32'hF2);
    beat(2'd3, 32'hF3);
    chk("t6_mask_cleared", smp_valid, 1'b0);
    beat(2'd0, 32'hF0);
    beat(2'd1, 32'hF1);
    issue_chk(8'h68, mk_exp(32'hF0, 32'hF1, 32'hF2, 32'hF3));
    step;
    chk("t6_done", smp_valid, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/tex_texel_gather.md
# tex_texel_gather

Assembles texture sampler requests from the texel-fetch side of the texture unit. Accepts one request header per quad (format, bilinear blend fractions, tag) from the address stage. Collects the four corner-texel memory beats for that quad, in any corner order. Once all four corners are present, it issues a single sampler request carrying the complete 2x2 texel set. It is the producer/initiator of the texture sampler's request interface.

## Interface
Parameters:
- NUM_LANES, 4, lanes per quad request
- REQ_TAGW, 8, request tag width
- HDR_DEPTH, 4, header FIFO entries (power of two, >= 2)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low (0 = reset)
- hdr_valid  in  1  header valid
- hdr_format  in  `TEX_FORMAT_BITS  texel format
- hdr_blends  in  NUM_LANES x 2 x `TEX_BLEND_FRAC  per-lane {v,u} fractions
- hdr_tag  in  REQ_TAGW  request tag
- hdr_ready  out  1  header accepted
- mem_valid  in  1  texel beat valid
- mem_idx  in  2  corner index 0..3 (0=ul-lo, 1=ul-hi, 2=uh-lo, 3=uh-hi)
- mem_data  in  NUM_LANES x 32  texel per lane for that corner
- mem_ready  out  1  beat accepted
- smp_valid  out  1  sampler request valid
- smp_format  out  `TEX_FORMAT_BITS
- smp_blends  out  NUM_LANES x 2 x `TEX_BLEND_FRAC
- smp_data  out  NUM_LANES x 4 x 32  texels, index [lane][corner]
- smp_tag  out  REQ_TAGW
- smp_ready  in  1  sampler accepts
- dup_err  out  1  sticky: a corner was received twice for one quad

## Operation
- Header FIFO: HDR_DEPTH entries of {format, blends, tag}, in-order.
  - Push on hdr_valid && hdr_ready.
  - hdr_ready = !full; depends on occupancy only, never on a same-cycle pop.
- Beats always belong to the oldest header (the FIFO head). The memory system returns quads in header order.
- Assembly state: corner mask[3:0] and texel buffer NUM_LANES x 4 x 32. FSM states:
  - GATHER:
    - mem_ready = FIFO non-empty.
    - On an accepted beat: write buffer[*][mem_idx] and set mask[mem_idx].
    - If mask[mem_idx] was already set: overwrite the data and set dup_err; the mask is unchanged.
    - When the beat completes mask == 4'b1111, go to ISSUE.
  - ISSUE:
    - mem_ready = 0.
    - smp_valid = 1. smp_format/blends/tag come from the FIFO head; smp_data comes from the buffer.
    - All smp_* outputs hold stable while smp_valid && !smp_ready.
    - On smp_ready: pop the head, clear the mask, go to GATHER.
- dup_err clears only on reset.
- Buffer contents outside ISSUE are don't-care. The mask is authoritative.

## Timing
- Reset (reset==0 at a clk edge) forces the following:
  - FSM = GATHER, mask = 0, FIFO empty, dup_err = 0.
  - hdr_ready = 1, mem_ready = 0, smp_valid = 0.
  - smp_* data outputs = 0.
- Reset asserted mid-quad discards partial beats and all queued headers. No request is issued for them.
- Header pushed into an empty FIFO at cycle N: mem_ready = 1 from cycle N+1. A beat offered at cycle N is not accepted.
- Fourth beat accepted at cycle N: smp_valid = 1 at N+1.
  - If smp_ready = 1 at N+1, the handshake fires. mem_ready = 1 again at N+2 when another header is queued.
  - Peak rate: 1 quad per 5 cycles.
- Full FIFO with a same-cycle ISSUE pop: hdr_ready stays 0 that cycle. The push succeeds the next cycle.
- Header push and a pop in the same cycle with FIFO non-full: both occur and the count is unchanged.
- FIFO pointers wrap modulo HDR_DEPTH. Full/empty are distinguished by an extra pointer bit or by a count.
- No combinational path from smp_ready to mem_ready, or from hdr_valid to any output.

## Test plan
- Single quad, in-order corners:
  - Stimulus: header tag=0x11 then beats idx 0,1,2,3 with data 0xA0..0xA3 (lane 0).
  - Expected: smp_valid one cycle after the idx 3 beat; smp_data[0] = {A3,A2,A1,A0}; tag 0x11.
- Out-of-order corners:
  - Stimulus: beats idx 3,1,0,2.
  - Expected: each corner placed by index; single issue; dup_err = 0.
- Backpressure:
  - Stimulus: hold smp_ready = 0 for 6 cycles in ISSUE.
  - Expected: outputs stable, mem_ready = 0. Issue fires on the first smp_ready = 1 cycle, then GATHER.
- FIFO full:
  - Stimulus: push 4 headers without beats.
  - Expected: hdr_ready = 0 on the 5th. After the first quad completes and pops, hdr_ready = 1 the next cycle. Tags exit in order across a wrap (push 8 total).
- Duplicate corner:
  - Stimulus: beats idx 0,0(data 0xB0),1,2,3.
  - Expected: dup_err = 1 and sticky; issued corner 0 = 0xB0; exactly 4 distinct corners required before issue.
- Reset mid-quad:
  - Stimulus: 2 beats accepted, reset = 0 for 1 cycle.
  - Expected: FIFO empty, mask = 0, hdr_ready = 1. No smp_valid until a fresh header and 4 beats arrive.
